// File: rtl/next_pc_if.sv
// Branch/fetch bundle between the control side (control unit, register file, ALU)
// and the next-PC unit.
interface next_pc_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       cond_jump;
    logic             uncond_jump;
    logic [1:0]       addr_sel;
    logic [25:0]      imm;
    logic [31:0]      rs_data;
    logic             carry_we;
    logic             carry_in;
    logic             stall;
    logic             halt_req;
    logic             resume;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             branch_taken;
    logic             carry_flag;
    logic             running;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output cond_jump, uncond_jump, addr_sel, imm, rs_data,
               carry_we, carry_in, stall, halt_req, resume,
        input  pc, pc_plus4, branch_taken, carry_flag, running, taken_count
    );

    modport slave (
        input  cond_jump, uncond_jump, addr_sel, imm, rs_data,
               carry_we, carry_in, stall, halt_req, resume,
        output pc, pc_plus4, branch_taken, carry_flag, running, taken_count
    );
endinterface

// File: rtl/next_pc_unit.sv
// miniRISC next-PC unit: architectural PC, carry flag, branch evaluation,
// taken-branch counter and BOOT/RUN/HALT sequencing.
module next_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    next_pc_if.slave    bus
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] pc_plus4;
    logic [31:0] off26, off16, target;
    logic        cond_true, taken, in_run, advance;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign pc_plus4 = pc_q + 32'd4;
    assign off26    = {{4{bus.imm[25]}}, bus.imm, 2'b00};
    assign off16    = {{14{bus.imm[15]}}, bus.imm[15:0], 2'b00};
    assign in_run   = (state_q == S_RUN);

    always_comb begin
        target = pc_plus4;
        case (bus.addr_sel)
            2'b00:   target = pc_plus4 + off26;
            2'b01:   target = {bus.rs_data[31:2], 2'b00};
            2'b10:   target = pc_plus4 + off16;
            default: target = pc_plus4;
        endcase
    end

    // Conditions read the registered flag so an ALU write in this cycle is seen next cycle.
    always_comb begin
        cond_true = 1'b0;
        case (bus.cond_jump)
            3'b001:  cond_true = bus.rs_data[31];
            3'b010:  cond_true = (bus.rs_data == 32'd0);
            3'b011:  cond_true = (bus.rs_data != 32'd0);
            3'b100:  cond_true = carry_q;
            3'b101:  cond_true = ~carry_q;
            default: cond_true = 1'b0;
        endcase
    end

    assign taken   = in_run & (bus.uncond_jump | cond_true);
    assign advance = in_run & ~bus.stall & ~bus.halt_req;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (bus.halt_req) state_d = S_HALT;
            S_HALT:  if (bus.resume)   state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (advance) begin
            pc_d = taken ? target : pc_plus4;
            if (taken) cnt_d = sat_inc(cnt_q);
        end
        if (in_run && !bus.stall && bus.carry_we) carry_d = bus.carry_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_plus4;
    assign bus.branch_taken = taken;
    assign bus.carry_flag   = carry_q;
    assign bus.running      = in_run;
    assign bus.taken_count  = cnt_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit; a second narrow-counter instance mirrors the
// stimulus so counter saturation is reached in a handful of branches.
module tb_next_pc_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    next_pc_if #(.CNT_W(16)) bus ();
    next_pc_if #(.CNT_W(4))  sbus ();

    assign sbus.cond_jump   = bus.cond_jump;
    assign sbus.uncond_jump = bus.uncond_jump;
    assign sbus.addr_sel    = bus.addr_sel;
    assign sbus.imm         = bus.imm;
    assign sbus.rs_data     = bus.rs_data;
    assign sbus.carry_we    = bus.carry_we;
    assign sbus.carry_in    = bus.carry_in;
    assign sbus.stall       = bus.stall;
    assign sbus.halt_req    = bus.halt_req;
    assign sbus.resume      = bus.resume;

    next_pc_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    next_pc_unit #(.RESET_PC(32'h0), .CNT_W(4))  dut_sat (.clk(clk), .rst(rst), .bus(sbus));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] cj, input logic uj, input logic [1:0] as,
                         input logic [25:0] im, input logic [31:0] rs);
        bus.cond_jump   = cj;
        bus.uncond_jump = uj;
        bus.addr_sel    = as;
        bus.imm         = im;
        bus.rs_data     = rs;
    endtask

    task automatic seq();
        drive(3'b000, 1'b0, 2'b11, 26'h0, 32'h0);
    endtask

    task automatic jump_to(input logic [31:0] a);
        drive(3'b000, 1'b1, 2'b01, 26'h0, a);
        tick();
        exp_cnt++;
        chk("jump_to", 64'(bus.pc), 64'(a));
        seq();
    endtask

    initial begin
        seq();
        bus.carry_we = 1'b0;
        bus.carry_in = 1'b0;
        bus.stall    = 1'b0;
        bus.halt_req = 1'b0;
        bus.resume   = 1'b0;
        #2 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (17) tick();
        chk("pc_before_rst", 64'(bus.pc), 64'h40);

        // Asynchronous reset mid-run.
        rst = 1'b1;
        #1;
        chk("rst_pc", 64'(bus.pc), 64'h0);
        chk("rst_running", 64'(bus.running), 64'h0);
        chk("rst_cnt", 64'(bus.taken_count), 64'h0);
        chk("rst_carry", 64'(bus.carry_flag), 64'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("boot_running", 64'(bus.running), 64'h0);
        chk("boot_taken", 64'(bus.branch_taken), 64'h0);
        tick();
        chk("boot_pc", 64'(bus.pc), 64'h0);
        chk("run_after_boot", 64'(bus.running), 64'h1);
        tick();
        chk("seq_4", 64'(bus.pc), 64'h4);
        tick();
        chk("seq_8", 64'(bus.pc), 64'h8);
        tick();
        chk("seq_c", 64'(bus.pc), 64'hC);
        chk("seq_cnt", 64'(bus.taken_count), 64'h0);

        // b backward from 0x100.
        jump_to(32'h100);
        drive(3'b000, 1'b1, 2'b00, 26'h3FF_FFFE, 32'h0);
        #1;
        chk("b_pc_plus4", 64'(bus.pc_plus4), 64'h104);
        chk("b_taken", 64'(bus.branch_taken), 64'h1);
        tick();
        exp_cnt++;
        chk("b_back_pc", 64'(bus.pc), 64'hFC);
        chk("b_cnt", 64'(bus.taken_count), 64'(exp_cnt));

        // br with low bits cleared, then b forward.
        drive(3'b000, 1'b1, 2'b01, 26'h0, 32'h0000_2003);
        tick();
        exp_cnt++;
        chk("br_pc", 64'(bus.pc), 64'h2000);
        drive(3'b000, 1'b1, 2'b00, 26'h10, 32'h0);
        tick();
        exp_cnt++;
        chk("b_fwd_pc", 64'(bus.pc), 64'h2044);

        // Conditional branches at 0x20 with imm16 = 4.
        jump_to(32'h20);
        drive(3'b010, 1'b0, 2'b10, 26'h0004, 32'h0);
        tick();
        exp_cnt++;
        chk("bz_zero", 64'(bus.pc), 64'h34);
        jump_to(32'h20);
        drive(3'b010, 1'b0, 2'b10, 26'h0004, 32'h5);
        #1;
        chk("bz_nz_taken", 64'(bus.branch_taken), 64'h0);
        tick();
        chk("bz_nonzero", 64'(bus.pc), 64'h24);
        jump_to(32'h20);
        drive(3'b001, 1'b0, 2'b10, 26'h0004, 32'h8000_0000);
        tick();
        exp_cnt++;
        chk("bltz_neg", 64'(bus.pc), 64'h34);
        jump_to(32'h20);
        drive(3'b011, 1'b0, 2'b10, 26'h0004, 32'h0);
        tick();
        chk("bnz_zero", 64'(bus.pc), 64'h24);
        drive(3'b011, 1'b0, 2'b10, 26'h0004, 32'h7);
        tick();
        exp_cnt++;
        chk("bnz_nonzero", 64'(bus.pc), 64'h38);
        drive(3'b110, 1'b0, 2'b10, 26'h0004, 32'h0);
        #1;
        chk("code110_taken", 64'(bus.branch_taken), 64'h0);
        drive(3'b010, 1'b1, 2'b10, 26'h0004, 32'h5);
        tick();
        exp_cnt++;
        chk("uncond_dominates", 64'(bus.pc), 64'h4C);

        // Carry timing: flag written at 0x4C, bcy there sees the old flag.
        drive(3'b100, 1'b0, 2'b10, 26'h0001, 32'h0);
        bus.carry_we = 1'b1;
        bus.carry_in = 1'b1;
        #1;
        chk("bcy_old_flag", 64'(bus.branch_taken), 64'h0);
        tick();
        bus.carry_we = 1'b0;
        chk("carry_set", 64'(bus.carry_flag), 64'h1);
        chk("bcy_n_pc", 64'(bus.pc), 64'h50);
        tick();
        exp_cnt++;
        chk("bcy_n1_pc", 64'(bus.pc), 64'h58);
        drive(3'b101, 1'b0, 2'b10, 26'h0001, 32'h0);
        #1;
        chk("bncy_taken", 64'(bus.branch_taken), 64'h0);
        tick();
        chk("bncy_pc", 64'(bus.pc), 64'h5C);

        // Stall during a taken b: hold, then a single redirect.
        drive(3'b000, 1'b1, 2'b00, 26'h4, 32'h0);
        bus.stall    = 1'b1;
        bus.carry_we = 1'b1;
        bus.carry_in = 1'b0;
        #1;
        chk("stall_taken", 64'(bus.branch_taken), 64'h1);
        tick();
        chk("stall1_pc", 64'(bus.pc), 64'h5C);
        tick();
        chk("stall2_pc", 64'(bus.pc), 64'h5C);
        chk("stall_cnt", 64'(bus.taken_count), 64'(exp_cnt));
        chk("stall_carry", 64'(bus.carry_flag), 64'h1);
        bus.stall    = 1'b0;
        bus.carry_we = 1'b0;
        tick();
        exp_cnt++;
        chk("stall_release_pc", 64'(bus.pc), 64'h70);
        chk("stall_release_cnt", 64'(bus.taken_count), 64'(exp_cnt));
        seq();

        // Halt at 0x80.
        jump_to(32'h80);
        bus.halt_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_pc", 64'(bus.pc), 64'h80);
            chk("halt_running", 64'(bus.running), 64'h0);
            drive(3'b000, 1'b1, 2'b00, 26'h10, 32'h0);
            #1;
            chk("halt_taken", 64'(bus.branch_taken), 64'h0);
        end
        chk("halt_cnt", 64'(bus.taken_count), 64'(exp_cnt));
        seq();
        bus.halt_req = 1'b0;
        bus.resume   = 1'b1;
        tick();
        bus.resume = 1'b0;
        chk("resume_running", 64'(bus.running), 64'h1);
        chk("resume_pc", 64'(bus.pc), 64'h80);
        tick();
        chk("after_resume_pc", 64'(bus.pc), 64'h84);
        bus.halt_req = 1'b1;
        bus.resume   = 1'b1;
        tick();
        chk("halt_over_resume", 64'(bus.running), 64'h0);
        bus.halt_req = 1'b0;
        tick();
        bus.resume = 1'b0;
        chk("rerun", 64'(bus.running), 64'h1);

        // pc_plus4 wraps at 2^32.
        jump_to(32'hFFFF_FFFC);
        chk("wrap_plus4", 64'(bus.pc_plus4), 64'h0);
        tick();
        chk("wrap_pc", 64'(bus.pc), 64'h0);

        // Counter saturation on the narrow instance.
        drive(3'b000, 1'b1, 2'b11, 26'h0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_cnt++;
        end
        seq();
        chk("sat_cnt", 64'(sbus.taken_count), 64'hF);
        tick();
        chk("sat_hold", 64'(sbus.taken_count), 64'hF);
        chk("main_cnt", 64'(bus.taken_count), 64'(exp_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
